uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of byte requesters (2..16) sharing one uart_tx Wishbone device.
REQ-002 Parameter DAT_WIDTH, default 8, width of one UART data frame.
REQ-003 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset; synchronous and active-high.
REQ-005 req_valid_i  input  NUM_REQ  per-requester byte-pending flag.
REQ-006 req_data_i  input  NUM_REQ*DAT_WIDTH  per-requester byte; requester i occupies bits [i*DAT_WIDTH +: DAT_WIDTH].
REQ-007 req_done_o  output  NUM_REQ  one-hot, single-cycle pulse meaning "byte sent" to the granted requester.
REQ-008 grant_o  output  NUM_REQ  one-hot index of the current owner; all-zero when idle.
REQ-009 cyc_o, stb_o  output  1 each  Wishbone controller cycle and strobe toward uart_tx.
REQ-010 dat_o  output  DAT_WIDTH  Wishbone write data toward uart_tx.
REQ-011 stall_i, ack_i  input  1 each  Wishbone pipelined stall and acknowledge from uart_tx.

Function
REQ-012 The FSM SHALL have three states: IDLE, STROBE and WAIT_ACK.
REQ-013 IDLE: cyc_o=0, stb_o=0, grant_o=0; if any req_valid_i bit is set, choose the winner, latch its req_data_i into dat_o, set grant_o, and go to STROBE on the next edge.
REQ-014 Winner selection SHALL be round-robin: search starts at index last_grant+1 and wraps modulo NUM_REQ; the first set valid bit wins.
REQ-015 last_grant SHALL update to the winner index at the IDLE->STROBE transition.
REQ-016 STROBE: cyc_o=1 and stb_o=1; if stall_i=0, go to WAIT_ACK next edge; if stall_i=1, stay in STROBE holding dat_o and grant_o stable.
REQ-017 WAIT_ACK: cyc_o=1, stb_o=0; dat_o and grant_o stay held until ack_i.
REQ-018 ack_i=1 in STROBE (with stall_i=0) or in WAIT_ACK SHALL drive req_done_o[winner]=1 combinationally in that same cycle and return the FSM to IDLE on the next edge.
REQ-019 ack_i in IDLE, or in STROBE with stall_i=1, SHALL be ignored: no req_done_o pulse and no state change.
REQ-020 The latched dat_o is the byte sent; req_valid_i or req_data_i changing after the grant SHALL NOT abort or alter the transfer.
REQ-021 A requester that holds req_valid_i high after its req_done_o pulse SHALL be treated as having a new byte pending, and arbitration proceeds normally.
REQ-022 Minimum spacing SHALL be one IDLE cycle between consecutive transfers; cyc_o SHALL drop for at least one cycle between transfers.
REQ-023 At most one req_done_o bit SHALL be set in any cycle, and only the bit matching grant_o.
REQ-024 grant_o SHALL be one-hot in STROBE and WAIT_ACK, and zero in IDLE.

Reset
REQ-025 rst_i=1 SHALL, on the next edge, force state=IDLE, cyc_o=0, stb_o=0, grant_o=0, req_done_o=0, dat_o=0, and last_grant=NUM_REQ-1, so requester 0 has first priority.
REQ-026 Reset in STROBE or WAIT_ACK SHALL abandon the transfer with no req_done_o pulse; a late ack_i after reset SHALL be ignored per REQ-019.
REQ-027 Reset SHALL take priority over every other event in the same cycle.

Verification
REQ-028 Single requester: after reset, req_valid_i=4'b0100 with byte 0xA5, stall_i=0, ack_i four cycles later -> dat_o=0xA5; grant_o=4'b0100 one cycle after valid; exactly one req_done_o[2] pulse in the ack cycle; IDLE next cycle.
REQ-029 Fairness: all four valids held high through 8 transfers -> grant order 0,1,2,3,0,1,2,3; each req_done_o bit pulses exactly twice.
REQ-030 Stall: stall_i=1 for 5 cycles during STROBE -> stb_o held high for 6 cycles; dat_o and grant_o constant; no req_done_o pulse until ack_i.
REQ-031 Data change after grant: req_data_i[0] changes 0x11->0x22 after grant -> dat_o remains 0x11 until req_done_o[0].
REQ-032 Mid-transfer reset in WAIT_ACK, then ack_i=1 one cycle later -> cyc_o=0 and no req_done_o pulse; the next grant goes to the lowest-index valid requester.
REQ-033 Stray ack_i in IDLE and in stalled STROBE -> no req_done_o pulse and no state change.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
// Pipelined Wishbone write channel between the byte arbiter (master) and a
// uart_tx device (slave).
//   cyc_o   : bus cycle in progress          (master -> slave)
//   stb_o   : write strobe, one byte offered (master -> slave)
//   dat_o   : byte being written             (master -> slave)
//   stall_i : slave cannot take the strobe   (slave -> master)
//   ack_i   : byte accepted by the slave     (slave -> master)
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
   parameter int DAT_WIDTH = 8
);
   logic                 cyc_o;
   logic                 stb_o;
   logic [DAT_WIDTH-1:0] dat_o;
   logic                 stall_i;
   logic                 ack_i;

   modport master (
      output cyc_o, stb_o, dat_o,
      input  stall_i, ack_i
   );

   modport slave (
      input  cyc_o, stb_o, dat_o,
      output stall_i, ack_i
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one uart_tx Wishbone device between NUM_REQ byte requesters using
// round-robin arbitration. One byte moves per bus cycle; the winner's byte is
// captured at grant time and held until the slave acknowledges it.
//   clk_i       : clock, all state changes on the rising edge
//   rst_i       : synchronous active-high reset
//   req_valid_i : per-requester byte-pending flags
//   req_data_i  : per-requester bytes, requester i at [i*DAT_WIDTH +: DAT_WIDTH]
//   req_done_o  : one-hot pulse to the granted requester when its byte is acked
//   grant_o     : one-hot current owner, zero while idle
//   wb          : Wishbone master port toward uart_tx
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DAT_WIDTH = 8
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [NUM_REQ-1:0]           req_valid_i,
   input  logic [NUM_REQ*DAT_WIDTH-1:0] req_data_i,
   output logic [NUM_REQ-1:0]           req_done_o,
   output logic [NUM_REQ-1:0]           grant_o,
   uart_tx_arbiter_if.master            wb
);

   localparam int IDX_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      STROBE   = 2'd1,
      WAIT_ACK = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [DAT_WIDTH-1:0] dat_q, dat_d;
   logic [IDX_W-1:0]     last_q, last_d;

   logic                 win_found;
   logic [IDX_W-1:0]     win_idx;
   logic                 accept;

   // Round-robin search: start one past the last winner and wrap, so the
   // previous owner has lowest priority for the next byte.
   // NOTE: combinational blocks use blocking '=' and give every output a
   // default at the top; a path that leaves a variable unassigned infers a latch.
   always_comb begin
      int               cand;
      logic [IDX_W-1:0] cand_idx;
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      cand_idx  = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = int'(last_q) + i;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         cand_idx = IDX_W'(cand);
         if (!win_found && req_valid_i[cand_idx]) begin
            win_found = 1'b1;
            win_idx   = cand_idx;
         end
      end
   end

   // Next-state logic. grant is cleared on every return to IDLE so it is
   // one-hot exactly while the bus cycle is open.
   always_comb begin
      int base;
      state_d = state_q;
      grant_d = grant_q;
      dat_d   = dat_q;
      last_d  = last_q;
      accept  = 1'b0;
      base    = int'(win_idx) * DAT_WIDTH;

      case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d = STROBE;
               grant_d = NUM_REQ'(1) << win_idx;
               dat_d   = req_data_i[base +: DAT_WIDTH];
               last_d  = win_idx;
            end
         end

         STROBE: begin
            // A stalled strobe was not taken, so any ack seen with it is stray.
            if (!wb.stall_i) begin
               if (wb.ack_i) begin
                  accept  = 1'b1;
                  state_d = IDLE;
                  grant_d = '0;
               end else begin
                  state_d = WAIT_ACK;
               end
            end
         end

         WAIT_ACK: begin
            if (wb.ack_i) begin
               accept  = 1'b1;
               state_d = IDLE;
               grant_d = '0;
            end
         end

         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking '<=' so every flop samples the
   // pre-edge values. All registers here are small and are reset, including
   // the data byte, so dat_o is defined straight out of reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         grant_q <= '0;
         dat_q   <= '0;
         last_q  <= IDX_W'(NUM_REQ - 1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         dat_q   <= dat_d;
         last_q  <= last_d;
      end
   end

   assign wb.cyc_o = (state_q != IDLE);
   assign wb.stb_o = (state_q == STROBE);
   assign wb.dat_o = dat_q;
   assign grant_o  = grant_q;

   // The done pulse is combinational from ack; reset wins, so a transfer cut
   // short by reset never reports completion.
   assign req_done_o = (accept && !rst_i) ? grant_q : '0;

endmodule
